// File: rtl/ma_pkg.sv
// Shared constants and sizing helper for the moving-average filter.
package ma_pkg;
  localparam int MODE_SLIDE = 0;
  localparam int MODE_BLOCK = 1;

  // N samples of WIDTH-bit signed data need LOG2_N extra bits of headroom.
  function automatic int sum_width(input int width, input int log2_n);
    return width + log2_n;
  endfunction
endpackage

// File: rtl/ma_sample_ram.sv
// N x WIDTH circular sample store: one synchronous write, combinational read at the same address.
module ma_sample_ram #(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [LOG2_N-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);
  logic [WIDTH-1:0] r_mem [2**LOG2_N];

  // Read returns the entry being overwritten this cycle (the sample leaving the window).
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end
endmodule

// File: rtl/moving_average_window.sv
// Signed moving-average / block-average filter with optional non-negative sample counting.
module moving_average_window
  import ma_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LOG2_N = 5,
  parameter int MODE   = MODE_SLIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sign_mode,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  avg_out,
  output logic              avg_valid,
  output logic              full,
  output logic [LOG2_N:0]   fill_level
);
  localparam int SW = sum_width(WIDTH, LOG2_N);
  localparam logic [LOG2_N:0] N_FILL = {1'b1, {LOG2_N{1'b0}}};

  logic signed [SW-1:0] r_sum;
  logic [LOG2_N-1:0]    r_wr_ptr;
  logic [LOG2_N:0]      r_fill;
  logic                 r_sign_q;
  logic [WIDTH-1:0]     r_avg;
  logic                 r_vld;
  logic                 r_full;

  logic                 w_sign_eff;
  logic signed [SW-1:0] w_term;
  logic signed [SW-1:0] w_old;
  logic signed [SW-1:0] w_sum_nxt;
  logic [LOG2_N:0]      w_fill_inc;
  logic                 w_emit;
  logic [WIDTH-1:0]     w_res;
  logic [WIDTH-1:0]     w_rd;

  // An empty window takes the live sign_mode so the first sample already uses it.
  assign w_sign_eff = (r_fill == '0) ? sign_mode : r_sign_q;
  assign w_term     = w_sign_eff ? {{(SW-1){1'b0}}, ~data_in[WIDTH-1]}
                                 : {{(SW-WIDTH){data_in[WIDTH-1]}}, data_in};
  assign w_old      = (MODE == MODE_SLIDE && r_fill == N_FILL)
                      ? {{(SW-WIDTH){w_rd[WIDTH-1]}}, w_rd} : '0;
  assign w_sum_nxt  = r_sum + w_term - w_old;
  assign w_fill_inc = (r_fill == N_FILL) ? N_FILL : r_fill + 1'b1;
  assign w_emit     = in_valid && !clear && (w_fill_inc == N_FILL);
  // Top WIDTH bits of the sum are exactly sum >>> LOG2_N truncated (floor toward -inf).
  assign w_res      = w_sign_eff ? {{(WIDTH-LOG2_N-1){1'b0}}, w_sum_nxt[LOG2_N:0]}
                                 : w_sum_nxt[SW-1:LOG2_N];

  generate
    if (MODE == MODE_SLIDE) begin : g_ram
      ma_sample_ram #(.WIDTH(WIDTH), .LOG2_N(LOG2_N)) u_ram (
        .clk     (clk),
        .i_we    (in_valid && !clear),
        .i_addr  (r_wr_ptr),
        .i_wdata (w_term[WIDTH-1:0]),
        .o_rdata (w_rd)
      );
    end else begin : g_no_ram
      assign w_rd = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum    <= '0;
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_sign_q <= 1'b0;
      r_avg    <= '0;
      r_vld    <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (r_fill == '0) r_sign_q <= sign_mode;
      if (clear) begin
        r_sum    <= '0;
        r_wr_ptr <= '0;
        r_fill   <= '0;
        r_full   <= 1'b0;
      end else begin
        if (MODE == MODE_BLOCK) r_full <= w_emit;
        if (in_valid) begin
          if (MODE == MODE_BLOCK && w_emit) begin
            r_sum  <= '0;
            r_fill <= '0;
          end else begin
            r_sum  <= w_sum_nxt;
            r_fill <= w_fill_inc;
          end
          if (MODE == MODE_SLIDE) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_full   <= (w_fill_inc == N_FILL);
          end
          if (w_emit) begin
            r_vld <= 1'b1;
            r_avg <= w_res;
          end
        end
      end
    end
  end

  assign avg_out    = r_avg;
  assign avg_valid  = r_vld;
  assign full       = r_full;
  assign fill_level = r_fill;
endmodule

// File: tb/tb_moving_average_window.sv
// Drives three filters (slide N=4, block N=4, slide N=32) with one stream; checks them against a window model.
module tb_moving_average_window;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clear = 1'b0;
  logic               sign_mode = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] data_in = '0;

  logic [15:0] a_avg, b_avg, c_avg;
  logic        a_vld, b_vld, c_vld, a_full, b_full, c_full;
  logic [2:0]  a_fill, b_fill;
  logic [5:0]  c_fill;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  moving_average_window #(.WIDTH(16), .LOG2_N(2), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .sign_mode(sign_mode), .in_valid(in_valid),
    .data_in(data_in), .avg_out(a_avg), .avg_valid(a_vld), .full(a_full), .fill_level(a_fill));
  moving_average_window #(.WIDTH(16), .LOG2_N(2), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .sign_mode(sign_mode), .in_valid(in_valid),
    .data_in(data_in), .avg_out(b_avg), .avg_valid(b_vld), .full(b_full), .fill_level(b_fill));
  moving_average_window #(.WIDTH(16), .LOG2_N(5), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .sign_mode(sign_mode), .in_valid(in_valid),
    .data_in(data_in), .avg_out(c_avg), .avg_valid(c_vld), .full(c_full), .fill_level(c_fill));

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: window kept as an ordered list of terms, average by floor division.
  localparam int LG [3] = '{2, 2, 5};
  localparam int MD [3] = '{0, 1, 0};
  int win [3][32];
  int cnt [3];
  int sm [3];
  int e_avg [3];
  int e_vld [3];
  int e_full [3];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      int n, s, t;
      if (rst) begin
        cnt[k] = 0; sm[k] = 0; e_avg[k] = 0; e_vld[k] = 0; e_full[k] = 0;
      end else begin
        n = 1 << LG[k];
        e_vld[k] = 0;
        if (cnt[k] == 0) sm[k] = int'(sign_mode);
        if (clear) begin
          cnt[k] = 0;
          e_full[k] = 0;
        end else if (in_valid) begin
          t = (sm[k] != 0) ? ((data_in >= 0) ? 1 : 0) : int'(data_in);
          if (MD[k] == 0 && cnt[k] == n) begin
            for (int j = 0; j < n - 1; j++) win[k][j] = win[k][j+1];
            win[k][n-1] = t;
          end else begin
            win[k][cnt[k]] = t;
            cnt[k]++;
          end
          if (cnt[k] == n) begin
            s = 0;
            for (int j = 0; j < n; j++) s += win[k][j];
            if (sm[k] != 0)  e_avg[k] = s;
            else if (s >= 0) e_avg[k] = s / n;
            else             e_avg[k] = -((-s + n - 1) / n);
            e_vld[k] = 1;
            if (MD[k] == 1) cnt[k] = 0;
          end
          if (MD[k] == 0) e_full[k] = (cnt[k] == n) ? 1 : 0;
        end
        if (MD[k] == 1) e_full[k] = e_vld[k];
      end
    end
  end

  always @(negedge clk) begin
    chk("A.avg_out", int'(a_avg), e_avg[0] & 32'hFFFF);
    chk("A.avg_valid", int'(a_vld), e_vld[0]);
    chk("A.full", int'(a_full), e_full[0]);
    chk("A.fill_level", int'(a_fill), cnt[0]);
    chk("B.avg_out", int'(b_avg), e_avg[1] & 32'hFFFF);
    chk("B.avg_valid", int'(b_vld), e_vld[1]);
    chk("B.full", int'(b_full), e_full[1]);
    chk("B.fill_level", int'(b_fill), cnt[1]);
    chk("C.avg_out", int'(c_avg), e_avg[2] & 32'hFFFF);
    chk("C.avg_valid", int'(c_vld), e_vld[2]);
    chk("C.full", int'(c_full), e_full[2]);
    chk("C.fill_level", int'(c_fill), cnt[2]);
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic c);
    in_valid = v;
    data_in  = d;
    clear    = c;
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rv;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset avg_out", int'(a_avg), 0);
    chk("reset avg_valid", int'(a_vld), 0);
    chk("reset full", int'(a_full), 0);
    chk("reset fill_level", int'(a_fill), 0);

    // sliding average
    cyc(1, 16'd4, 0);  chk("T1 s1 no strobe", int'(a_vld), 0);
    cyc(1, 16'd8, 0);  chk("T1 s2 no strobe", int'(a_vld), 0);
    cyc(1, 16'd12, 0); chk("T1 s3 no strobe", int'(a_vld), 0);
    cyc(1, 16'd16, 0);
    chk("T1 strobe", int'(a_vld), 1);
    chk("T1 avg 10", int'(a_avg), 10);
    chk("T1 full", int'(a_full), 1);
    cyc(1, 16'd20, 0);
    chk("T1 avg 14", int'(a_avg), 14);

    // negatives floor toward -inf
    cyc(0, 16'd0, 1);
    cyc(1, 16'hFFFC, 0); cyc(1, 16'hFFFC, 0); cyc(1, 16'hFFFC, 0); cyc(1, 16'hFFFD, 0);
    chk("T2 avg -4", int'(a_avg), 32'hFFFC);

    // block mode
    cyc(0, 16'd0, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 16'(i), 0);
      chk("T3 block strobe", int'(b_vld), (i % 4 == 0) ? 1 : 0);
      if (i == 4) begin
        chk("T3 avg 2", int'(b_avg), 2);
        chk("T3 fill back to 0", int'(b_fill), 0);
      end
    end
    chk("T3 avg 6", int'(b_avg), 6);
    chk("T3 fill back to 0 again", int'(b_fill), 0);

    // sign-density mode
    sign_mode = 1'b1;
    cyc(0, 16'd0, 1);
    cyc(1, 16'd5, 0); cyc(1, 16'hFFFF, 0); cyc(1, 16'd0, 0); cyc(1, 16'hFFF9, 0);
    chk("T4 count 2", int'(a_avg), 2);
    cyc(1, 16'hFFFE, 0);
    chk("T4 count 1", int'(a_avg), 1);
    sign_mode = 1'b0;
    cyc(1, 16'd3, 0);
    chk("T4 latch holds", int'(a_avg), 2);

    // clear beats in_valid
    cyc(0, 16'd0, 1);
    cyc(1, 16'd1, 0); cyc(1, 16'd2, 0);
    cyc(1, 16'd99, 1);
    chk("T5 fill 0", int'(a_fill), 0);
    chk("T5 no strobe", int'(a_vld), 0);
    cyc(1, 16'd1, 0); cyc(1, 16'd2, 0); cyc(1, 16'd3, 0);
    chk("T5 still no strobe", int'(a_vld), 0);
    cyc(1, 16'd4, 0);
    chk("T5 strobe", int'(a_vld), 1);
    chk("T5 avg 2", int'(a_avg), 2);

    // extremes
    cyc(0, 16'd0, 1);
    repeat (4) cyc(1, 16'h7FFF, 0);
    chk("T6 max", int'(a_avg), 32'h7FFF);
    cyc(0, 16'd0, 1);
    repeat (4) cyc(1, 16'h8000, 0);
    chk("T6 min", int'(a_avg), 32'h8000);
    cyc(1, 16'd8, 0); cyc(1, 16'd8, 0);
    #2 rst = 1'b1;
    #1;
    chk("T6 async avg_out", int'(a_avg), 0);
    chk("T6 async fill", int'(a_fill), 0);
    chk("T6 async full", int'(a_full), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      cyc(1, 16'd8, 0);
      chk("T6 recovery no strobe", int'(a_vld), 0);
    end
    cyc(1, 16'd8, 0);
    chk("T6 recovery strobe", int'(a_vld), 1);
    chk("T6 recovery avg 8", int'(a_avg), 8);

    // back-to-back random stream, mostly valid, occasional flush
    cyc(0, 16'd0, 1);
    for (int i = 0; i < 400; i++) begin
      sign_mode = ($urandom_range(0, 7) == 0);
      rv = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rv = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
      cyc($urandom_range(0, 7) != 0, rv, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
